// File: rtl/rw_txn_scheduler_pkg.sv
// rw_txn_pkg: shared types and default sizing for the read/write transaction
// scheduler (rw_txn_scheduler) and its round-robin picker (rw_rr_arb2).
package rw_txn_pkg;

    // Scheduler sequencing states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        WR   = 3'd2,
        RD   = 3'd3,
        GAP  = 3'd4,
        DONE = 3'd5
    } state_t;

    // Which requester was served most recently
    typedef enum logic {
        SIDE_WR = 1'b0,
        SIDE_RD = 1'b1
    } side_t;

    localparam int DEF_NUM_TXN    = 5;
    localparam int DEF_RD_LEN     = 2;
    localparam int DEF_GAP_CYCLES = 1;

endpackage

// File: rtl/rw_txn_scheduler_rr_arb2.sv
// rw_rr_arb2: two-way round-robin picker for the write and read requesters.
// On a tie the side that was not served last wins; after reset the read side
// counts as last served, so the write side wins the very first tie.
module rw_rr_arb2
    import rw_txn_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic wr_elig,
    input  logic rd_elig,
    input  logic advance,
    output logic pick_wr,
    output logic pick_rd
);

    side_t last_grant_r;

    // Choose a side from the eligible set, alternating on a tie
    always_comb begin
        pick_wr = 1'b0;
        pick_rd = 1'b0;
        if (wr_elig && rd_elig) begin
            if (last_grant_r == SIDE_RD) begin
                pick_wr = 1'b1;
            end else begin
                pick_rd = 1'b1;
            end
        end else begin
            pick_wr = wr_elig;
            pick_rd = rd_elig;
        end
    end

    // Remember the side granted when the scheduler commits to a pick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= SIDE_RD;
        end else if (advance && pick_wr) begin
            last_grant_r <= SIDE_WR;
        end else if (advance && pick_rd) begin
            last_grant_r <= SIDE_RD;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/rw_txn_scheduler.sv
// rw_txn_scheduler: runs one session of NUM_TXN writes and NUM_TXN reads onto
// a shared wr/rd port pair, arbitrating fairly between the two requesters.
// Each write strobe is one cycle, each read strobe RD_LEN cycles, and every
// strobe is followed by GAP_CYCLES idle cycles. All outputs are flops.
// Optional build macro RW_TXN_SCHEDULER_SVA_EN compiles embedded protocol
// assertions; behaviour is identical with or without it.
module rw_txn_scheduler
    import rw_txn_pkg::*;
#(
    parameter int  NUM_TXN    = DEF_NUM_TXN,
    parameter int  RD_LEN     = DEF_RD_LEN,
    parameter int  GAP_CYCLES = DEF_GAP_CYCLES,
    localparam int CW         = $clog2(NUM_TXN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          wr_req,
    input  logic          rd_req,
    output logic          wr,
    output logic          rd,
    output logic          wr_gnt,
    output logic          rd_gnt,
    output logic [CW-1:0] wr_cnt,
    output logic [CW-1:0] rd_cnt,
    output logic          busy,
    output logic          done
);

    // Shared down-counter for read length and idle gap
    localparam int LMAX = (RD_LEN > GAP_CYCLES) ? RD_LEN : GAP_CYCLES;
    localparam int LW   = $clog2(LMAX + 1);

    state_t        state_r;
    logic [CW-1:0] wr_cnt_r;
    logic [CW-1:0] rd_cnt_r;
    logic [LW-1:0] len_r;
    logic          wr_r;
    logic          rd_r;
    logic          wr_gnt_r;
    logic          rd_gnt_r;
    logic          busy_r;
    logic          done_r;

    logic          wr_elig_s;
    logic          rd_elig_s;
    logic          all_done_s;
    logic          advance_s;
    logic          pick_wr_s;
    logic          pick_rd_s;

    // Eligibility: an exhausted side is never offered to the picker
    always_comb begin
        wr_elig_s  = wr_req && (wr_cnt_r < CW'(NUM_TXN));
        rd_elig_s  = rd_req && (rd_cnt_r < CW'(NUM_TXN));
        all_done_s = (wr_cnt_r == CW'(NUM_TXN)) && (rd_cnt_r == CW'(NUM_TXN));
        advance_s  = (state_r == ARB) && !all_done_s;
    end

    rw_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .wr_elig (wr_elig_s),
        .rd_elig (rd_elig_s),
        .advance (advance_s),
        .pick_wr (pick_wr_s),
        .pick_rd (pick_rd_s)
    );

    // Session FSM; strobe, grant and status flops are set on entry to a state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            wr_cnt_r <= '0;
            rd_cnt_r <= '0;
            len_r    <= '0;
            wr_r     <= 1'b0;
            rd_r     <= 1'b0;
            wr_gnt_r <= 1'b0;
            rd_gnt_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            wr_r     <= 1'b0;
            rd_r     <= 1'b0;
            wr_gnt_r <= 1'b0;
            rd_gnt_r <= 1'b0;
            done_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r  <= ARB;
                        wr_cnt_r <= '0;
                        rd_cnt_r <= '0;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r  <= IDLE;
                    end
                end
                ARB: begin
                    if (all_done_s) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else if (pick_wr_s) begin
                        state_r  <= WR;
                        wr_r     <= 1'b1;
                        wr_gnt_r <= 1'b1;
                    end else if (pick_rd_s) begin
                        state_r  <= RD;
                        rd_r     <= 1'b1;
                        rd_gnt_r <= 1'b1;
                        len_r    <= LW'(RD_LEN - 1);
                    end else begin
                        state_r  <= ARB;
                    end
                end
                WR: begin
                    state_r  <= GAP;
                    wr_cnt_r <= wr_cnt_r + CW'(1);
                    len_r    <= LW'(GAP_CYCLES - 1);
                end
                RD: begin
                    if (len_r == LW'(0)) begin
                        state_r  <= GAP;
                        rd_cnt_r <= rd_cnt_r + CW'(1);
                        len_r    <= LW'(GAP_CYCLES - 1);
                    end else begin
                        rd_r     <= 1'b1;
                        len_r    <= len_r - LW'(1);
                    end
                end
                GAP: begin
                    if (len_r == LW'(0)) begin
                        state_r <= ARB;
                    end else begin
                        len_r   <= len_r - LW'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign wr     = wr_r;
    assign rd     = rd_r;
    assign wr_gnt = wr_gnt_r;
    assign rd_gnt = rd_gnt_r;
    assign wr_cnt = wr_cnt_r;
    assign rd_cnt = rd_cnt_r;
    assign busy   = busy_r;
    assign done   = done_r;

`ifdef RW_TXN_SCHEDULER_SVA_EN
    a_rd_len: assert property (@(posedge clk) disable iff (rst)
        $rose(rd) |-> rd[*RD_LEN] ##1 !rd);
    a_no_overlap: assert property (@(posedge clk) disable iff (rst)
        !(wr && rd));
    a_all_writes: assert property (@(posedge clk) disable iff (rst)
        $rose(busy) |-> $rose(wr)[->NUM_TXN]);
    a_done_counts: assert property (@(posedge clk) disable iff (rst)
        done |-> (wr_cnt == CW'(NUM_TXN)) && (rd_cnt == CW'(NUM_TXN)));
    a_gnt_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0({wr_gnt, rd_gnt}));
`endif

endmodule

// File: tb/tb_rw_txn_scheduler.sv
// Scoreboard bench for rw_txn_scheduler: stimulus pushes expected grant/done
// events, a negedge monitor pops and compares them and checks strobe shape.
module tb_rw_txn_scheduler;

    localparam int N1  = 5;
    localparam int RL1 = 2;
    localparam int G1  = 1;

    logic       clk = 1'b0;
    logic       rst, start, wr_req, rd_req;
    logic       wr, rd, wr_gnt, rd_gnt, busy, done;
    logic [2:0] wr_cnt, rd_cnt;

    logic       start2, req2;
    logic       wr2, rd2, wr_gnt2, rd_gnt2, busy2, done2;
    logic [1:0] wr_cnt2, rd_cnt2;

    rw_txn_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .wr_req(wr_req), .rd_req(rd_req),
        .wr(wr), .rd(rd), .wr_gnt(wr_gnt), .rd_gnt(rd_gnt),
        .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .busy(busy), .done(done)
    );

    rw_txn_scheduler #(.NUM_TXN(3), .RD_LEN(3), .GAP_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .wr_req(req2), .rd_req(req2),
        .wr(wr2), .rd(rd2), .wr_gnt(wr_gnt2), .rd_gnt(rd_gnt2),
        .wr_cnt(wr_cnt2), .rd_cnt(rd_cnt2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;   // 0 write grant, 1 read grant, 2 done
        int wc;
        int rc;
        int at;     // expected cycle, -1 when not timed
    } ev_t;

    ev_t exp_q[$];
    bit  strict = 1'b1;
    int  tal_w = 0, tal_r = 0, done_seen = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_ev(input int kind, input int wc, input int rc, input int at);
        ev_t e;
        e.kind = kind; e.wc = wc; e.rc = rc; e.at = at;
        exp_q.push_back(e);
    endtask

    // Default session with both sides always requesting: W/R pair every 7 cycles
    task automatic push_full(input int s);
        for (int i = 0; i < N1; i++) begin
            push_ev(0, i, i, s + 1 + 7 * i);
            push_ev(1, i + 1, i, s + 4 + 7 * i);
        end
        push_ev(2, N1, N1, s + 36);
    endtask

    task automatic take(input int kind);
        ev_t e;
        if (!strict && kind != 2) begin
            if (kind == 0) check("wr_cnt_at_gnt", wr_cnt, tal_w);
            else           check("rd_cnt_at_gnt", rd_cnt, tal_r);
        end else if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: got kind %0d expected none", kind);
        end else begin
            e = exp_q.pop_front();
            check("ev_kind", kind, e.kind);
            check("ev_wr_cnt", wr_cnt, e.wc);
            check("ev_rd_cnt", rd_cnt, e.rc);
            if (e.at >= 0) check("ev_cycle", cyc, e.at);
        end
        if (kind == 0)      tal_w++;
        else if (kind == 1) tal_r++;
        else                done_seen++;
    endtask

    logic wr_q = 1'b0, rd_q = 1'b0, busy_q = 1'b0;
    int   rd_run = 0, idle_run = 0;
    bit   seen_strobe = 1'b0;

    // Monitor: strobe shape, spacing and scoreboard pops
    always @(negedge clk) begin
        if (rst) begin
            wr_q = 1'b0; rd_q = 1'b0; busy_q = 1'b0;
            rd_run = 0; idle_run = 0; seen_strobe = 1'b0;
        end else begin
            if (busy && !busy_q) begin
                tal_w = 0; tal_r = 0; seen_strobe = 1'b0; idle_run = 0;
            end
            check("no_overlap", wr & rd, 0);
            if (wr) check("wr_single_cycle", wr_q, 0);
            if (rd) rd_run++;
            else if (rd_q) begin
                check("rd_run_len", rd_run, RL1);
                rd_run = 0;
            end
            if ((wr && !wr_q) || (rd && !rd_q)) begin
                if (seen_strobe) check("idle_gap_min", (idle_run >= G1) ? 1 : 0, 1);
                seen_strobe = 1'b1;
                idle_run = 0;
            end else if (!wr && !rd) begin
                idle_run++;
            end
            if (wr_gnt) begin
                check("wr_gnt_with_wr", wr, 1);
                take(0);
            end
            if (rd_gnt) begin
                check("rd_gnt_first_cycle", rd && !rd_q, 1);
                take(1);
            end
            if (done) begin
                check("busy_low_in_done", busy, 0);
                take(2);
            end
            wr_q = wr; rd_q = rd; busy_q = busy;
        end
    end

    // Pulse start at the current negedge; returns the index of the sampling edge
    task automatic pulse_start(output int s);
        start = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("FAIL %s: got no done expected done within %0d cycles", name, budget);
        end
    endtask

    initial begin
        int s;
        int d0;
        int n;
        bit e_wr, e_rd, e_done, e_busy;
        rst = 1'b1; start = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        start2 = 1'b0; req2 = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_wr", wr, 0);
        check("rst_rd", rd, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_cnt", wr_cnt, 0);
        check("rst_rd_cnt", rd_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        // Both requesters always on; stray start mid-session and in DONE
        wr_req = 1'b1; rd_req = 1'b1; strict = 1'b1;
        pulse_start(s);
        push_full(s);
        repeat (10) @(negedge clk);
        check("busy_mid_session", busy, 1);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        wait_done(60, "t1_done");
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        check("start_in_done_ignored", busy, 0);
        @(negedge clk);
        check("t1_hold_wr_cnt", wr_cnt, N1);
        check("t1_hold_rd_cnt", rd_cnt, N1);
        check("t1_queue_empty", exp_q.size(), 0);
        pulse_start(s);
        push_full(s);
        wait_done(60, "t5_done");
        @(negedge clk);
        check("t5_queue_empty", exp_q.size(), 0);

        // Write side only, then reads released after the stall
        wr_req = 1'b1; rd_req = 1'b0;
        pulse_start(s);
        for (int i = 0; i < N1; i++) push_ev(0, i, 0, s + 1 + 3 * i);
        repeat (20) @(negedge clk);
        check("stall_busy", busy, 1);
        check("stall_done", done, 0);
        check("stall_wr_cnt", wr_cnt, N1);
        check("stall_rd_cnt", rd_cnt, 0);
        check("stall_wr_low", wr, 0);
        for (int i = 0; i < N1; i++) push_ev(1, N1, i, -1);
        push_ev(2, N1, N1, -1);
        rd_req = 1'b1;
        wait_done(60, "t2_done");
        @(negedge clk);
        check("t2_queue_empty", exp_q.size(), 0);

        // Requesters drop for 1-3 cycles after each grant
        strict = 1'b0;
        d0 = done_seen;
        push_ev(2, N1, N1, -1);
        pulse_start(s);
        fork
            begin : wgen
                int g;
                int k;
                g = 0; k = 0;
                while (g < N1 && k < 300) begin
                    @(negedge clk); k++;
                    if (wr_gnt) begin
                        g++;
                        if (g < N1) begin
                            wr_req = 1'b0;
                            repeat ($urandom_range(1, 3)) @(negedge clk);
                            wr_req = 1'b1;
                        end
                    end
                end
            end
            begin : rgen
                int g;
                int k;
                g = 0; k = 0;
                while (g < N1 && k < 300) begin
                    @(negedge clk); k++;
                    if (rd_gnt) begin
                        g++;
                        if (g < N1) begin
                            rd_req = 1'b0;
                            repeat ($urandom_range(1, 3)) @(negedge clk);
                            rd_req = 1'b1;
                        end
                    end
                end
            end
        join
        wait_done(60, "t3_done");
        repeat (6) @(negedge clk);
        check("t3_writes", tal_w, N1);
        check("t3_reads", tal_r, N1);
        check("t3_done_once", done_seen - d0, 1);
        strict = 1'b1;

        // Reset during the second cycle of the first read
        wr_req = 1'b1; rd_req = 1'b1;
        pulse_start(s);
        push_ev(0, 0, 0, s + 1);
        push_ev(1, 1, 0, s + 4);
        n = 0;
        while (rd_gnt !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("t4_saw_rd_gnt", rd_gnt, 1);
        @(negedge clk);
        check("t4_rd_second_cycle", rd, 1);
        rst = 1'b1;
        #1;
        check("t4_rst_rd", rd, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_wr_cnt", wr_cnt, 0);
        check("t4_rst_rd_cnt", rd_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        check("t4_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        pulse_start(s);
        push_full(s);
        wait_done(60, "t4_rerun_done");
        @(negedge clk);
        check("t4_rerun_queue_empty", exp_q.size(), 0);

        // Overridden instance: NUM_TXN=3, RD_LEN=3, GAP_CYCLES=2, 10-cycle W/R pairs
        start2 = 1'b1; @(posedge clk); #1; s = cyc; start2 = 1'b0;
        for (int t = 0; t <= 33; t++) begin
            @(negedge clk);
            e_wr   = (t >= 1 && t <= 21 && ((t - 1) % 10) == 0);
            e_rd   = 1'b0;
            for (int i = 0; i < 3; i++) if (t >= 5 + 10 * i && t <= 7 + 10 * i) e_rd = 1'b1;
            e_done = (t == 31);
            e_busy = (t <= 30);
            check("d2_wr", wr2, e_wr);
            check("d2_rd", rd2, e_rd);
            check("d2_done", done2, e_done);
            check("d2_busy", busy2, e_busy);
        end
        check("d2_wr_cnt", wr_cnt2, 3);
        check("d2_rd_cnt", rd_cnt2, 3);

        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rw_txn_scheduler.md
Name: rw_txn_scheduler

Overview:
- Sequences a fixed-length session of write and read strobes onto a shared wr/rd port pair on behalf of two requesters (write side, read side).
- Fair round-robin arbitration; write strobe is one cycle, read strobe is RD_LEN consecutive cycles, and an enforced idle gap follows every strobe.
- A one-cycle done pulse marks completion.
- Sits between traffic generators and the memory/FIFO port that the property checks watch.

Parameters:
- NUM_TXN, 5, writes and reads issued per session (each side), >=1.
- RD_LEN, 2, cycles rd is held high per read, >=1.
- GAP_CYCLES, 1, idle cycles (wr=rd=0) after every strobe, >=1.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse, begins a session; ignored while busy=1.
- wr_req  in  1  write requester level request; held until wr_gnt seen.
- rd_req  in  1  read requester level request; held until rd_gnt seen.
- wr  out  1  write strobe to shared port.
- rd  out  1  read strobe to shared port.
- wr_gnt  out  1  one-cycle grant, coincident with wr.
- rd_gnt  out  1  one-cycle grant, coincident with first rd cycle.
- wr_cnt  out  CW  writes issued this session, CW = $clog2(NUM_TXN+1).
- rd_cnt  out  CW  reads issued this session.
- busy  out  1  session active.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async assert, any state): state=IDLE; wr, rd, wr_gnt, rd_gnt, busy, done = 0; wr_cnt = rd_cnt = 0; last_grant = RD, so write wins the first tie. Mid-strobe reset drops wr/rd immediately.
- All outputs are decoded from registered state/counters only; no input-to-output combinational path.
- States: IDLE, ARB, WR, RD, GAP, DONE.
- IDLE:
  - start=1 -> clear counts, go ARB.
  - busy=1 from the ARB cycle onward.
- ARB:
  - Eligible sides: wr_elig = wr_req && wr_cnt<NUM_TXN; rd_elig = rd_req && rd_cnt<NUM_TXN.
  - Both eligible -> grant the side opposite last_grant.
  - One eligible -> grant it.
  - Both counts == NUM_TXN -> DONE.
  - Otherwise stay in ARB. A request from an exhausted side is ignored, not granted.
- WR:
  - Exactly one cycle: wr=1, wr_gnt=1.
  - wr_cnt increments at exit; last_grant=WR; -> GAP.
- RD:
  - rd=1 for exactly RD_LEN cycles (internal length counter); rd_gnt=1 on the first cycle only.
  - rd_cnt increments at exit; last_grant=RD; -> GAP.
- GAP:
  - wr=rd=0 for exactly GAP_CYCLES cycles, then -> ARB.
  - Guarantees rd[*RD_LEN] ##1 !rd, and that wr never stays high across consecutive cycles.
- DONE:
  - done=1 and busy=0 for one cycle, -> IDLE. Counts hold their final values until the next start.
- Latency:
  - start sampled at edge k -> ARB during cycle k+1.
  - Request present in ARB at edge k+1 -> strobe high during cycle k+2.
  - Minimum strobe-to-strobe spacing: 1+GAP_CYCLES+1 cycles for writes, RD_LEN+GAP_CYCLES+1 cycles for reads.
- Edge cases:
  - start coincident with rst: rst wins.
  - start during DONE: ignored.
  - A request dropped before grant is simply not granted.
  - Counters never exceed NUM_TXN; no wrap.

Optional Feature:
- Macro: RW_TXN_SCHEDULER_SVA_EN.
- Defined: embedded concurrent assertions, all disabled iff rst:
  - $rose(rd) |-> rd[*RD_LEN] ##1 !rd
  - !(wr && rd)
  - $rose(busy) |-> $rose(wr)[->NUM_TXN]
  - done |-> wr_cnt==NUM_TXN && rd_cnt==NUM_TXN
  - $onehot0({wr_gnt, rd_gnt})
- Undefined: no assertion code compiled; RTL behaviour identical.

Decomposition:
- Package rw_txn_pkg holds:
  - state enum typedef (IDLE, ARB, WR, RD, GAP, DONE);
  - grant-side enum (SIDE_WR, SIDE_RD);
  - default-value localparams.
- One natural sub-module: rw_rr_arb2, the 2-way round-robin picker with last_grant register (inputs wr_elig/rd_elig/advance, outputs pick_wr/pick_rd).

Test Plan:
- Both requesters always asserted, defaults -> strobes alternate W,R,W,R… (write first). 5 wr pulses of 1 cycle, 5 rd pulses of 2 cycles, each followed by >=1 idle cycle; done pulses once; wr_cnt=rd_cnt=5.
- Only wr_req asserted -> 5 writes, then ARB stalls with busy=1, done=0. Raise rd_req -> 5 reads follow, then done.
- Random request gaps of 1-3 cycles on each side -> never wr&&rd; every rd run is exactly 2 cycles; done exactly once after 10 strobes.
- Assert rst during a read's 2nd cycle -> rd=0 immediately, counts=0, busy=0. A new start re-runs the full session from zero.
- start pulsed while busy, and again in the DONE cycle -> ignored; counts unaffected. start one cycle after DONE -> new session.
- Overrides NUM_TXN=3, RD_LEN=3, GAP_CYCLES=2 -> rd high exactly 3 cycles, 2 idle cycles after each strobe, done after 3 of each.
